// File: rtl/tpu_dist_sq_unit.sv
// Pipelined pair-distance unit: r^2 = dx^2 + dy^2 + dz^2 in Q8.8, rounded and saturated.
// Optional macro DIST_SQ_CUTOFF_FILTER_EN drops out-of-range beats when they load S3.
module tpu_dist_sq_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [3*DATA_WIDTH-1:0] in_pos_a,
  input  logic [3*DATA_WIDTH-1:0] in_pos_b,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   cutoff_sq,
  output logic [DATA_WIDTH-1:0]   out_r2,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_in_range,
  output logic                    out_zero,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             pairs_in,
  output logic [31:0]             pairs_culled,
  output logic [31:0]             sat_count
);

  localparam int FRAC = DATA_WIDTH / 2;
  localparam int DW   = DATA_WIDTH + 1;
  localparam int SQW  = 2 * DW;
  localparam int SUMW = SQW + 1;
  localparam logic [SUMW-1:0] HALF = SUMW'(1) << (FRAC - 1);

  logic stall;
  logic advance;
  logic accept;
  logic cull;

  // Input capture register, then S1 differences, S2 squares, S3 rounded result.
  logic                         s0_valid_q, s0_valid_d;
  logic [3*DATA_WIDTH-1:0]      s0_a_q, s0_a_d;
  logic [3*DATA_WIDTH-1:0]      s0_b_q, s0_b_d;
  logic [TAG_WIDTH-1:0]         s0_tag_q, s0_tag_d;

  logic                         s1_valid_q, s1_valid_d;
  logic signed [DW-1:0]         s1_diff_q [3];
  logic signed [DW-1:0]         s1_diff_d [3];
  logic [TAG_WIDTH-1:0]         s1_tag_q, s1_tag_d;

  logic                         s2_valid_q, s2_valid_d;
  logic [SQW-1:0]               s2_sq_q [3];
  logic [SQW-1:0]               s2_sq_d [3];
  logic [TAG_WIDTH-1:0]         s2_tag_q, s2_tag_d;

  logic                         s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0]        s3_r2_q, s3_r2_d;
  logic [TAG_WIDTH-1:0]         s3_tag_q, s3_tag_d;
  logic                         s3_range_q, s3_range_d;
  logic                         s3_zero_q, s3_zero_d;
  logic                         s3_sat_q, s3_sat_d;

  logic [31:0]                  pairs_in_q, pairs_in_d;
  logic [31:0]                  culled_q, culled_d;
  logic [31:0]                  sat_cnt_q, sat_cnt_d;

  logic signed [DW-1:0]         diff_c [3];
  logic [SQW-1:0]               sq_c [3];
  logic [SUMW-1:0]              sum_c;
  logic [SUMW-1:0]              rounded_c;
  logic                         sat_c;
  logic                         zero_c;
  logic [DATA_WIDTH-1:0]        r2_c;
  logic                         range_c;

  assign stall    = s3_valid_q && !out_ready;
  assign advance  = enable && !stall;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic signed [SQW-1:0] dext;
    logic signed [SQW-1:0] prod;
    assign diff_c[gi] = DW'($signed(s0_a_q[gi*DATA_WIDTH +: DATA_WIDTH]))
                      - DW'($signed(s0_b_q[gi*DATA_WIDTH +: DATA_WIDTH]));
    assign dext      = SQW'(s1_diff_q[gi]);
    assign prod      = dext * dext;
    assign sq_c[gi]  = prod;
  end

  // Round half up by adding half an LSB of the Q8.8 result before truncating.
  assign sum_c     = SUMW'(s2_sq_q[0]) + SUMW'(s2_sq_q[1]) + SUMW'(s2_sq_q[2]);
  assign rounded_c = (sum_c + HALF) >> FRAC;
  assign sat_c     = |rounded_c[SUMW-1:DATA_WIDTH];
  assign zero_c    = (rounded_c == '0);
  assign r2_c      = sat_c ? {DATA_WIDTH{1'b1}} : rounded_c[DATA_WIDTH-1:0];
  assign range_c   = !sat_c && !zero_c && (r2_c <= cutoff_sq);

`ifdef DIST_SQ_CUTOFF_FILTER_EN
  assign cull = s2_valid_q && !range_c;
`else
  assign cull = 1'b0;
`endif

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_a_d     = s0_a_q;
    s0_b_d     = s0_b_q;
    s0_tag_d   = s0_tag_q;
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_sq_d    = s2_sq_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    s3_r2_d    = s3_r2_q;
    s3_tag_d   = s3_tag_q;
    s3_range_d = s3_range_q;
    s3_zero_d  = s3_zero_q;
    s3_sat_d   = s3_sat_q;
    pairs_in_d = pairs_in_q;
    culled_d   = culled_q;
    sat_cnt_d  = sat_cnt_q;

    // Every stage moves together; empty slots travel as bubbles.
    if (advance) begin
      s0_valid_d = in_valid;
      s0_a_d     = in_pos_a;
      s0_b_d     = in_pos_b;
      s0_tag_d   = in_tag;
      s1_valid_d = s0_valid_q;
      s1_diff_d  = diff_c;
      s1_tag_d   = s0_tag_q;
      s2_valid_d = s1_valid_q;
      s2_sq_d    = sq_c;
      s2_tag_d   = s1_tag_q;
      s3_valid_d = s2_valid_q && !cull;
      s3_r2_d    = r2_c;
      s3_tag_d   = s2_tag_q;
      s3_range_d = range_c;
      s3_zero_d  = zero_c;
      s3_sat_d   = sat_c;
      if (s2_valid_q && sat_c) sat_cnt_d = sat_cnt_q + 32'd1;
      if (cull)                culled_d  = culled_q + 32'd1;
    end
    if (accept) pairs_in_d = pairs_in_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_tag_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '{default: '0};
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sq_q    <= '{default: '0};
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_r2_q    <= '0;
      s3_tag_q   <= '0;
      s3_range_q <= 1'b0;
      s3_zero_q  <= 1'b0;
      s3_sat_q   <= 1'b0;
      pairs_in_q <= '0;
      culled_q   <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_a_q     <= s0_a_d;
      s0_b_q     <= s0_b_d;
      s0_tag_q   <= s0_tag_d;
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sq_q    <= s2_sq_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_r2_q    <= s3_r2_d;
      s3_tag_q   <= s3_tag_d;
      s3_range_q <= s3_range_d;
      s3_zero_q  <= s3_zero_d;
      s3_sat_q   <= s3_sat_d;
      pairs_in_q <= pairs_in_d;
      culled_q   <= culled_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid    = s3_valid_q;
  assign out_r2       = s3_r2_q;
  assign out_tag      = s3_tag_q;
  assign out_in_range = s3_range_q;
  assign out_zero     = s3_zero_q;
  assign out_sat      = s3_sat_q;
  assign pairs_in     = pairs_in_q;
  assign pairs_culled = culled_q;
  assign sat_count    = sat_cnt_q;

endmodule

// File: tb/tb_tpu_dist_sq_unit.sv
// Self-checking bench for tpu_dist_sq_unit: directed vector table, stall/enable/reset
// sequences and a randomized stream scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_tpu_dist_sq_unit;
  localparam int W  = 16;
  localparam int TW = 8;
`ifdef DIST_SQ_CUTOFF_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [3*W-1:0] in_pos_a = '0;
  logic [3*W-1:0] in_pos_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  cutoff_sq = '0;
  logic [W-1:0]  out_r2;
  logic [TW-1:0] out_tag;
  logic          out_in_range, out_zero, out_sat, out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   pairs_in, pairs_culled, sat_count;

  tpu_dist_sq_unit #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_pos_a(in_pos_a), .in_pos_b(in_pos_b), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready), .cutoff_sq(cutoff_sq),
    .out_r2(out_r2), .out_tag(out_tag), .out_in_range(out_in_range),
    .out_zero(out_zero), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready), .pairs_in(pairs_in), .pairs_culled(pairs_culled),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r2;
    logic [7:0]  tag;
    logic        zero;
    logic        sat;
    logic        rng;
  } exp_t;

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    logic [15:0] cut;
    logic [15:0] r2;
    logic        zero;
    logic        sat;
    logic        rng;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pairs_in = 0;
  int exp_sat      = 0;
  int exp_culled   = 0;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer distance, round half up, then clamp and classify.
  function automatic exp_t model(input logic [47:0] a, input logic [47:0] b,
                                 input logic [7:0] tag, input logic [15:0] cut);
    exp_t   e;
    longint s = 0;
    longint r;
    for (int i = 0; i < 3; i++) begin
      longint d;
      d = longint'($signed(a[16*i +: 16])) - longint'($signed(b[16*i +: 16]));
      s += d * d;
    end
    r      = (s + 128) / 256;
    e.tag  = tag;
    e.sat  = (r > 65535);
    e.zero = (r == 0);
    e.r2   = e.sat ? 16'hFFFF : 16'(r);
    e.rng  = !e.sat && !e.zero && (r <= longint'(cut));
    return e;
  endfunction

  function automatic logic [15:0] rand_coord(input int mode);
    case (mode)
      0:       return 16'($urandom_range(0, 2047)) - 16'd1024;
      1:       return 16'($urandom);
      default: return 16'($urandom_range(0, 255)) - 16'd128;
    endcase
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    int   lat;
    bit   emit;
    logic [15:0] r2;
    logic [7:0]  tg;
    logic        z, s, rg;
    v = tbl[idx];
    lat = 0;
    emit = !FILT || v.rng;
    r2 = '0; tg = '0; z = 0; s = 0; rg = 0;
    cutoff_sq = v.cut;
    in_pos_a  = v.a;
    in_pos_b  = v.b;
    in_tag    = 8'(idx);
    in_valid  = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c; r2 = out_r2; tg = out_tag; z = out_zero; s = out_sat; rg = out_in_range;
      end
    end
    exp_pairs_in++;
    if (v.sat) exp_sat++;
    if (FILT && !v.rng) exp_culled++;
    $display("vec %0d: lat=%0d r2=0x%04h tag=%0d zero=%0b sat=%0b range=%0b", idx, lat, r2, tg, z, s, rg);
    if (emit) begin
      check($sformatf("vec%0d_latency", idx), lat, 3);
      check($sformatf("vec%0d_r2", idx), r2, v.r2);
      check($sformatf("vec%0d_tag", idx), tg, idx);
      check($sformatf("vec%0d_zero", idx), z, v.zero);
      check($sformatf("vec%0d_sat", idx), s, v.sat);
      check($sformatf("vec%0d_range", idx), rg, v.rng);
    end else begin
      check($sformatf("vec%0d_culled_no_output", idx), lat, 0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain_and_check_counters(input string tag);
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_pairs_in"}, pairs_in, 32'(exp_pairs_in));
    check({tag, "_sat_count"}, sat_count, 32'(exp_sat));
    check({tag, "_pairs_culled"}, pairs_culled, 32'(exp_culled));
  endtask

  // Cycle-driven stream; called at #1 after a rising edge.
  task automatic run_stream(input string name, input int nbeats, input int st_lo, input int st_hi,
                            input int en_lo, input int en_hi, input bit rnd, input logic [15:0] cut);
    exp_t q[$];
    exp_t e;
    exp_t got_e;
    logic [28:0] prev_out;
    bit   prev_hold = 0;
    bit   pend = 0;
    bit   hs;
    int   sent = 0;
    int   got = 0;
    int   idle = 0;
    int   cyc;
    cutoff_sq = cut;
    for (cyc = 0; cyc < 4000 && idle < 6; cyc++) begin
      if (rnd) begin
        enable    = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        enable    = !(cyc >= en_lo && cyc < en_hi);
        out_ready = !(cyc >= st_lo && cyc < st_hi);
      end
      if (!pend && sent < nbeats && (!rnd || $urandom_range(0, 3) != 0)) begin
        pend = 1;
        in_tag = 8'(sent);
        if (rnd) begin
          int mode;
          mode = $urandom_range(0, 3);
          for (int i = 0; i < 3; i++) begin
            in_pos_a[16*i +: 16] = rand_coord(mode == 2 ? 0 : mode);
            in_pos_b[16*i +: 16] = rand_coord(mode == 2 ? 0 : mode);
          end
          if (mode == 2) in_pos_b = in_pos_a;
        end else begin
          in_pos_a = {16'h0000, 16'h0000, 16'((sent + 1) * 256)};
          in_pos_b = '0;
        end
      end
      in_valid = pend;
      #1;
      check({name, "_in_ready"}, in_ready, enable && !(out_valid && !out_ready));
      if (prev_hold)
        check({name, "_out_stable"}, {out_r2, out_tag, out_zero, out_sat, out_in_range}, prev_out);
      hs = out_valid && out_ready && enable;
      if (hs) begin
        if (q.size() == 0) begin
          check({name, "_unexpected_beat_tag"}, out_tag, 8'hFF);
        end else begin
          got_e = q.pop_front();
          got++;
          $display("%s beat: tag=%0d r2=0x%04h zero=%0b sat=%0b range=%0b", name, out_tag, out_r2, out_zero, out_sat, out_in_range);
          check({name, "_tag"}, out_tag, got_e.tag);
          check({name, "_r2"}, out_r2, got_e.r2);
          check({name, "_zero"}, out_zero, got_e.zero);
          check({name, "_sat"}, out_sat, got_e.sat);
          check({name, "_range"}, out_in_range, got_e.rng);
        end
      end
      prev_hold = out_valid && !hs;
      prev_out  = {out_r2, out_tag, out_zero, out_sat, out_in_range};
      if (in_valid && in_ready) begin
        e = model(in_pos_a, in_pos_b, in_tag, cut);
        exp_pairs_in++;
        if (e.sat) exp_sat++;
        if (FILT && !e.rng) exp_culled++;
        else q.push_back(e);
        sent++;
        pend = 0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (sent == nbeats && q.size() == 0) idle++;
    end
    check({name, "_finished_in_budget"}, idle >= 6, 1);
    check({name, "_queue_empty"}, q.size(), 0);
    if (!rnd) check({name, "_beats_out"}, got, nbeats);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{48'h0000_0000_0300, 48'h0, 16'h1000, 16'h0900, 0, 0, 1};
    tbl[1] = '{48'h0000_0000_FE00, 48'h0000_0000_0100, 16'h1000, 16'h0900, 0, 0, 1};
    tbl[2] = '{48'h0000_0000_000C, 48'h0, 16'h1000, 16'h0001, 0, 0, 1};
    tbl[3] = '{48'h0000_0000_0001, 48'h0, 16'h1000, 16'h0000, 1, 0, 0};
    tbl[4] = '{48'h0000_0000_7FFF, 48'h0000_0000_8000, 16'h1000, 16'hFFFF, 0, 1, 0};
    tbl[5] = '{48'h0000_0000_0100, 48'h0, 16'h0400, 16'h0100, 0, 0, 1};
    tbl[6] = '{48'h0000_0000_0300, 48'h0, 16'h0400, 16'h0900, 0, 0, 0};
    tbl[7] = '{48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 16'h0400, 16'h0000, 1, 0, 0};
    tbl[8] = '{48'hFF00_0200_FE00, 48'h0, 16'h0900, 16'h0900, 0, 0, 1};
    tbl[9] = '{48'hFF00_0200_FE00, 48'h0, 16'h08FF, 16'h0900, 0, 0, 0};

    // Reset state, and in_ready following enable out of reset.
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_r2", out_r2, 0);
    check("reset_pairs_in", pairs_in, 0);
    check("reset_in_ready_enable_low", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b1;
    #1;
    check("reset_in_ready_enable_high", in_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(i);
    drain_and_check_counters("table");

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      in_pos_a = {32'h0, 16'h0200}; in_pos_b = '0; in_tag = 8'(100 + i); in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    exp_pairs_in = 0; exp_sat = 0; exp_culled = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_pairs_in", pairs_in, 0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_pairs_culled", pairs_culled, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit ghost;
      ghost = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        if (out_valid) ghost = 1;
      end
      check("midrst_no_ghost_output", ghost, 0);
    end

    run_stream("bp", 8, 4, 9, -1, -1, 0, 16'hFFFF);
    drain_and_check_counters("bp");
    run_stream("en", 8, -1, -1, 3, 7, 0, 16'hFFFF);
    drain_and_check_counters("en");
    run_stream("rnd", 300, -1, -1, -1, -1, 1, 16'h2000);
    drain_and_check_counters("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_dist_sq_unit.md
# tpu_dist_sq_unit

Pipelined pair-distance front end for the molecular-dynamics rsqrt path. Computes r² = dx² + dy² + dz² from two signed Q8.8 position vectors. Rounds and saturates the result to unsigned Q8.8. Presents it, with a pair tag and range flags, on a valid/ready stream that feeds `tpu_rsqrt_unit` directly (`out_r2` drives `data_in`, `out_valid` drives `data_valid`).

## Interface
Parameters:
- DATA_WIDTH, 16, coordinate and r² width (Q8.8)
- TAG_WIDTH, 8, opaque pair identifier carried alongside each result

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  pipeline advance enable; low freezes all state and forces in_ready low
- in_pos_a  in  3×DATA_WIDTH  atom A {z,y,x}, signed Q8.8, x in bits [15:0]
- in_pos_b  in  3×DATA_WIDTH  atom B {z,y,x}, signed Q8.8
- in_tag  in  TAG_WIDTH  pair identifier
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready at clk edge
- cutoff_sq  in  DATA_WIDTH  unsigned Q8.8 cutoff radius²; sampled in stage 3
- out_r2  out  DATA_WIDTH  unsigned Q8.8 r², saturated
- out_tag  out  TAG_WIDTH  tag of out_r2
- out_in_range  out  1  r² nonzero, unsaturated, and ≤ cutoff_sq
- out_zero  out  1  rounded r² == 0 (self-pair or coincident atoms)
- out_sat  out  1  r² saturated to 0xFFFF
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready (tie to rsqrt data_ready)
- pairs_in  out  32  accepted input beats, wraps
- pairs_culled  out  32  beats dropped by the cutoff filter (0 when filter compiled out), wraps
- sat_count  out  32  saturated results produced, wraps

## Operation
- Stage 1 (S1): dx/dy/dz = a − b, 17-bit signed (Q9.8).
- Stage 2 (S2): squares, each 34-bit unsigned (Q18.16).
- Stage 3 (S3): sum is 35-bit. Rounded = (sum + 128) >> 8, round-half-up.
- Saturation: if rounded > 0xFFFF, then out_r2 = 0xFFFF and out_sat = 1.
- Zero flag: out_zero = (rounded == 0).
- Range flag: out_in_range = !sat && !zero && rounded ≤ cutoff_sq, unsigned compare.
- Tag travels with its data through every stage unchanged.
- Stall: stall = out_valid && !out_ready.
  - in_ready = enable && !stall, combinational.
  - When stall is high or enable is low, S1–S3 registers hold.
  - Otherwise every stage advances one slot.
  - Bubbles are not compressed.
- out_* hold stable while out_valid && !out_ready.
- Counters:
  - pairs_in increments on each accepted beat.
  - sat_count increments when a saturated beat loads S3.
  - pairs_culled increments per dropped beat (see Configuration).
  - Counters hold while enable is low.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+3, with no stall.
- Throughput: 1 beat/cycle while out_ready = 1.
- Reset (async assert, sync release):
  - all stage valids, out_* data, flags and counters = 0
  - out_valid = 0
  - in_ready = enable after reset
- Reset mid-operation discards all in-flight beats; no partial output.
- Simultaneous S3 output handshake and new S3 load in the same cycle: the new beat replaces the old one with no gap.
- enable low with out_valid = 1: out_valid stays 1, but no handshake completes (the pipeline does not advance).
- cutoff_sq changes take effect on the next beat loaded into S3.

## Configuration
- Macro: DIST_SQ_CUTOFF_FILTER_EN.
- Defined: beats with out_in_range = 0 are dropped at the S3 load. The S3 valid is cleared for that slot, pairs_culled increments, and the beat never reaches downstream. Zero and saturated pairs are therefore always dropped.
- Undefined: every beat is emitted with its flags, and pairs_culled stays 0.

## Test plan
- Basic:
  - Stimulus: a = (0x0300, 0, 0), b = 0, cutoff_sq = 0x1000.
  - Response: out_r2 = 0x0900, in_range = 1, valid 3 cycles after accept.
- Sign/rounding:
  - Stimulus: a.x = 0xFE00 (−2.0), b.x = 0x0100; separately a.x = 0x000C, b = 0; separately a.x = 0x0001, b = 0.
  - Response: r² = 0x0900 for the first; r² = 0x0001 (144 + 128 >> 8) for the second; r² = 0x0000 with out_zero = 1 for the third.
- Saturation:
  - Stimulus: a.x = 0x7FFF, b.x = 0x8000.
  - Response: out_r2 = 0xFFFF, out_sat = 1, sat_count = 1, in_range = 0.
- Backpressure:
  - Stimulus: stream 8 tagged beats (tags 0–7) and hold out_ready = 0 for 5 cycles mid-stream.
  - Response: in_ready low while stalled, out_* stable, all 8 tags emitted in order exactly once, pairs_in = 8.
- Filter:
  - Stimulus: with DIST_SQ_CUTOFF_FILTER_EN and cutoff_sq = 0x0400, send r² values of 0x0100, 0x0900 and 0.
  - Response: only the 0x0100 beat emitted; pairs_culled = 2. Without the macro, all 3 are emitted with in_range = 1, 0, 0.
- Reset/enable:
  - Stimulus: assert rst_n low with 3 beats in flight; separately drop enable for 4 cycles.
  - Response: after reset, no out_valid and all counters 0. With enable low, state frozen, then resumes with no loss.
